decrypt_key_sequencer: RTL and testbench

DECRYPT_KEY_SEQUENCER -- requirements
Module: decrypt_key_sequencer

---
 rtl/des_key_pkg.sv | 33 +++
 rtl/Permuted_Choice2.sv | 20 ++
 rtl/decrypt_key_sequencer.sv | 69 ++++++
 tb/tb_decrypt_key_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/des_key_pkg.sv
// des_key_pkg: DES key-schedule tables, widths, state encoding and rotation helpers
package des_key_pkg;
  localparam int KEY_W = 64;
  localparam int HALF_W = 28;
  localparam int SUBKEY_W = 48;
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };
  localparam logic [1:0] SHIFTS [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };
  typedef enum logic [1:0] {IDLE, ISSUE, FINISH} state_t;
  // Highest-numbered vector bit carries DES bit 1, for both the key and the C/D halves.
  function automatic logic [2*HALF_W:1] pc1(input logic [KEY_W:1] key);
    logic [2*HALF_W:1] r;
    for (int i = 0; i < 2*HALF_W; i++) r[2*HALF_W-i] = key[KEY_W+1-PC1[i]];
    return r;
  endfunction
  function automatic logic [HALF_W:1] rot(input logic [HALF_W:1] x, input logic [1:0] n, input logic right);
    logic [HALF_W:1] r1, r2;
    r1 = right ? {x[1], x[HALF_W:2]} : {x[HALF_W-1:1], x[HALF_W]};
    r2 = right ? {x[2:1], x[HALF_W:3]} : {x[HALF_W-2:1], x[HALF_W:HALF_W-1]};
    return n == 2'd2 ? r2 : n == 2'd1 ? r1 : x;
  endfunction
endpackage

// File: rtl/Permuted_Choice2.sv
// Permuted_Choice2: DES PC2 selection of 48 subkey bits from the 56-bit C/D pair
module Permuted_Choice2
  import des_key_pkg::*;
(
  input  logic [2*HALF_W:1] cd,
  output logic [SUBKEY_W:1] subkey
);
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };
  always_comb
    for (int i = 0; i < SUBKEY_W; i++) subkey[SUBKEY_W-i] = cd[2*HALF_W+1-PC2[i]];
endmodule

// File: rtl/decrypt_key_sequencer.sv
// decrypt_key_sequencer: issues the 16 DES round subkeys over a valid/ready handshake,
// K16..K1 with right rotations when DECRYPT=1, K1..K16 with left rotations otherwise.
module decrypt_key_sequencer
  import des_key_pkg::*;
#(
  parameter bit DECRYPT = 1'b1
) (
  input  logic                CLK,
  input  logic                RESET_BAR,
  input  logic                START,
  input  logic [KEY_W:1]      KEY_IN,
  input  logic                ABORT,
  input  logic                SUBKEY_READY,
  output logic [SUBKEY_W:1]   SUBKEY,
  output logic                SUBKEY_VALID,
  output logic [4:1]          ROUND,
  output logic                BUSY,
  output logic                DONE
);
  state_t state, state_n;
  logic [HALF_W:1] c, d, c_n, d_n, c_load, d_load;
  logic [4:1] round_n;
  logic [2*HALF_W:1] cd0;
  logic [SUBKEY_W:1] pc2_out;
  logic [1:0] amt;
  logic last;
  assign cd0 = pc1(KEY_IN);
  // Encryption pre-rotates by s(1) at load, so the last handshake needs no further rotation.
  assign c_load = DECRYPT ? cd0[2*HALF_W:HALF_W+1] : rot(cd0[2*HALF_W:HALF_W+1], 2'd1, 1'b0);
  assign d_load = DECRYPT ? cd0[HALF_W:1] : rot(cd0[HALF_W:1], 2'd1, 1'b0);
  assign amt = DECRYPT ? SHIFTS[ROUND] : (ROUND == 4'd15 ? 2'd0 : SHIFTS[ROUND + 4'd1]);
  assign last = ROUND == (DECRYPT ? 4'd0 : 4'd15);
  always_comb begin
    state_n = state;
    c_n = c;
    d_n = d;
    round_n = ROUND;
    if (ABORT) state_n = IDLE;
    else if (state == IDLE && START) begin
      state_n = ISSUE;
      c_n = c_load;
      d_n = d_load;
      round_n = DECRYPT ? 4'd15 : 4'd0;
    end else if (state == ISSUE && SUBKEY_READY) begin
      state_n = last ? FINISH : ISSUE;
      c_n = rot(c, amt, DECRYPT);
      d_n = rot(d, amt, DECRYPT);
      round_n = DECRYPT ? ROUND - 4'd1 : ROUND + 4'd1;
    end else if (state == FINISH) state_n = IDLE;
  end
  always_ff @(posedge CLK or negedge RESET_BAR) begin
    if (!RESET_BAR) begin
      state <= IDLE;
      c <= '0;
      d <= '0;
      ROUND <= '0;
    end else begin
      state <= state_n;
      c <= c_n;
      d <= d_n;
      ROUND <= round_n;
    end
  end
  Permuted_Choice2 u_pc2 (.cd({c, d}), .subkey(pc2_out));
  assign SUBKEY_VALID = state == ISSUE;
  assign BUSY = state != IDLE;
  assign DONE = state == FINISH;
  assign SUBKEY = SUBKEY_VALID ? pc2_out : '0;
endmodule

// File: tb/tb_decrypt_key_sequencer.sv
// tb_decrypt_key_sequencer: scoreboard bench for both key orders of decrypt_key_sequencer
module tb_decrypt_key_sequencer;
  typedef struct packed { logic [47:0] k; logic [3:0] r; } exp_t;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [63:0] key = 64'h133457799BBCDFF1;
  logic [1:0] start = '0, abort = '0, ready = '0;
  logic [47:0] sk [2];
  logic [3:0] rnd [2];
  logic [1:0] vld, busy, done;
  exp_t q0[$], q1[$];
  int n_cmp = 0, n_bad = 0;
  int hs [2] = '{0, 0};
  int dones [2] = '{0, 0};
  logic [47:0] kt [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };
  always #5 clk = ~clk;
  decrypt_key_sequencer #(.DECRYPT(1'b1)) dut_d (
    .CLK(clk), .RESET_BAR(rst_n), .START(start[1]), .KEY_IN(key), .ABORT(abort[1]),
    .SUBKEY_READY(ready[1]), .SUBKEY(sk[1]), .SUBKEY_VALID(vld[1]), .ROUND(rnd[1]),
    .BUSY(busy[1]), .DONE(done[1]));
  decrypt_key_sequencer #(.DECRYPT(1'b0)) dut_e (
    .CLK(clk), .RESET_BAR(rst_n), .START(start[0]), .KEY_IN(key), .ABORT(abort[0]),
    .SUBKEY_READY(ready[0]), .SUBKEY(sk[0]), .SUBKEY_VALID(vld[0]), .ROUND(rnd[0]),
    .BUSY(busy[0]), .DONE(done[0]));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Monitor: every presented subkey is compared with the queue head; a handshake pops it.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) for (int i = 0; i < 2; i++) begin
      if (vld[i]) begin
        if ((i == 1 ? q1.size() : q0.size()) == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid dut%0d: got round %0d key %h expected no valid", i, rnd[i], sk[i]);
        end else begin
          e = i == 1 ? q1[0] : q0[0];
          chk("subkey", sk[i], e.k);
          chk("round", rnd[i], e.r);
          if (ready[i]) begin
            hs[i]++;
            if (i == 1) void'(q1.pop_front());
            else void'(q0.pop_front());
          end
        end
      end else chk("subkey_zero", sk[i], 0);
      if (done[i]) dones[i]++;
    end
  end
  task automatic push(input int i);
    for (int n = 0; n < 16; n++) begin
      exp_t e;
      int r = i == 1 ? 15 - n : n;
      e.k = kt[r];
      e.r = r[3:0];
      if (i == 1) q1.push_back(e);
      else q0.push_back(e);
    end
  endtask
  task automatic pulse_start(input int i);
    @(posedge clk); #1 start[i] = 1'b1;
    @(posedge clk); #1 start[i] = 1'b0;
  endtask
  task automatic run_seq(input int i, input bit poke);
    int c = 0;
    int d0 = dones[i];
    push(i);
    pulse_start(i);
    do begin
      @(negedge clk);
      c++;
      if (poke) start[i] = (c == 8 || c == 16);
    end while (!done[i] && c < 60);
    chk("done_latency", c, 17);
    chk("valid_at_done", vld[i], 0);
    @(negedge clk);
    chk("done_width", done[i], 0);
    chk("busy_after", busy[i], 0);
    repeat (3) @(negedge clk);
    chk("done_count", dones[i] - d0, 1);
    chk("queue_drained", i == 1 ? q1.size() : q0.size(), 0);
    start[i] = 1'b0;
  endtask
  initial begin
    int c, h0, d0;
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_valid", vld[i], 0);
      chk("rst_busy", busy[i], 0);
      chk("rst_done", done[i], 0);
      chk("rst_round", rnd[i], 0);
      chk("rst_subkey", sk[i], 0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    ready = 2'b11;
    run_seq(1, 1'b1);
    run_seq(0, 1'b0);
    // pseudo-random back-pressure on the decrypting instance
    push(1);
    h0 = hs[1];
    d0 = dones[1];
    ready[1] = 1'b0;
    pulse_start(1);
    c = 0;
    while (dones[1] == d0 && c < 400) begin
      @(posedge clk); #1 ready[1] = 1'($urandom_range(0, 1));
      c++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("stall_handshakes", hs[1] - h0, 16);
    chk("stall_done_count", dones[1] - d0, 1);
    chk("stall_queue", q1.size(), 0);
    ready[1] = 1'b1;
    // abort after the fifth handshake, with READY still high
    push(1);
    h0 = hs[1];
    d0 = dones[1];
    pulse_start(1);
    c = 0;
    while (hs[1] - h0 < 5 && c < 60) begin
      @(posedge clk); #1;
      c++;
    end
    chk("round_at_abort", rnd[1], 10);
    abort[1] = 1'b1;
    @(posedge clk); #1 abort[1] = 1'b0;
    q1.delete();
    @(negedge clk);
    chk("abort_valid", vld[1], 0);
    chk("abort_busy", busy[1], 0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", dones[1] - d0, 0);
    run_seq(1, 1'b0);
    // ABORT beats START in the same cycle
    @(posedge clk); #1 start[1] = 1'b1; abort[1] = 1'b1;
    @(posedge clk); #1 start[1] = 1'b0; abort[1] = 1'b0;
    chk("abort_over_start_busy", busy[1], 0);
    chk("abort_over_start_valid", vld[1], 0);
    // asynchronous reset in the middle of a sequence
    push(1);
    pulse_start(1);
    c = 0;
    while (!(vld[1] && rnd[1] == 4'd8) && c < 60) begin
      @(negedge clk);
      c++;
    end
    chk("reached_round8", rnd[1], 8);
    #2 rst_n = 1'b0;
    #1;
    q1.delete();
    chk("mid_rst_valid", vld[1], 0);
    chk("mid_rst_busy", busy[1], 0);
    chk("mid_rst_done", done[1], 0);
    chk("mid_rst_round", rnd[1], 0);
    chk("mid_rst_subkey", sk[1], 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_valid", vld[1], 0);
    chk("post_rst_busy", busy[1], 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
